// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug-port controller: command bytes, FSM states
// and the padded byte widths of the pipeline latch snapshots.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam logic [4:0] IF_ID_BYTES = 5'd8;
  localparam logic [4:0] ID_EX_BYTES = 5'd17;
  localparam logic [4:0] EX_M_BYTES  = 5'd10;
  localparam logic [4:0] M_WB_BYTES  = 5'd9;

  // Serializer buffer holds the widest latch (ID/EX padded to 17 bytes).
  localparam logic [4:0]  SER_MAX_BYTES = 5'd17;
  localparam int unsigned SER_BITS      = 136;

  typedef enum logic [4:0] {
    S_IDLE,
    S_LOAD,
    S_ACK_LD,
    S_ACK_TX,
    S_RUN,
    S_STEP,
    S_SNAP,
    S_REG_REQ,
    S_REG_LAT,
    S_REG_TX,
    S_LAT_LD,
    S_LAT_TX,
    S_MEM_REQ,
    S_MEM_LAT,
    S_MEM_TX,
    S_CSUM_LD,
    S_CSUM_TX
  } du_state_e;

endpackage

// File: rtl/du_word_serializer.sv
// Emits the low i_nbytes bytes of i_data MSB first over a valid/ready handshake;
// o_tx_valid drops for one cycle after each transfer, o_done pulses after the last.
module du_word_serializer
  import debug_unit_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [SER_BITS-1:0] i_data,
  input  logic [4:0]          i_nbytes,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_done
);

  logic [SER_BITS-1:0] shreg;
  logic [4:0]          remaining;

  assign o_tx_data = shreg[SER_BITS-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg      <= '0;
      remaining  <= '0;
      o_tx_valid <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_load) begin
        // Left-align so the most significant requested byte sits at the top.
        shreg      <= i_data << {(SER_MAX_BYTES - i_nbytes), 3'b000};
        remaining  <= i_nbytes;
        o_tx_valid <= 1'b1;
      end else if (o_tx_valid && i_tx_ready) begin
        shreg      <= shreg << 8;
        remaining  <= remaining - 5'd1;
        o_tx_valid <= 1'b0;
        if (remaining == 5'd1) o_done <= 1'b1;
      end else if (!o_tx_valid && remaining != 5'd0) begin
        o_tx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Host-side debug-port controller: UART commands drive instruction load, run,
// step and dump. Define DEBUG_UNIT_CHECKSUM_EN to append an XOR byte to dumps
// and the word count to the load acknowledge.
module debug_unit_ctrl
  import debug_unit_pkg::*;
#(
  parameter int unsigned NB_REGS        = 32,
  parameter int unsigned MEM_DUMP_WORDS = 32,
  parameter int unsigned MAX_INST       = 256,
  parameter logic [31:0] HALT_INST      = 32'hFFFF_FFFF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic [31:0]  o_du_data,
  output logic [31:0]  o_du_inst_addr_wr,
  output logic         o_du_write_en,
  output logic         o_du_read_en,
  output logic         o_du_pipeline_en,
  input  logic         i_du_halt,
  input  logic [63:0]  i_du_if_id_data,
  input  logic [129:0] i_du_id_ex_data,
  input  logic [75:0]  i_du_ex_m_data,
  input  logic [70:0]  i_du_m_wb_data,
  input  logic [31:0]  i_du_regs_mem_data,
  input  logic [31:0]  i_du_mem_data,
  output logic         o_busy
);

  du_state_e state;

  logic [31:0]  k;
  logic [1:0]   bcnt;
  logic [23:0]  word_acc;
  logic [31:0]  asm_word;
  logic [31:0]  idx;
  logic [1:0]   lat_sel;
  logic [63:0]  snap_if_id;
  logic [129:0] snap_id_ex;
  logic [75:0]  snap_ex_m;
  logic [70:0]  snap_m_wb;

  logic                ser_load;
  logic [SER_BITS-1:0] ser_data;
  logic [4:0]          ser_nbytes;
  logic                ser_done;

`ifdef DEBUG_UNIT_CHECKSUM_EN
  logic [7:0] csum;
  logic       in_dump;
`endif

  assign o_busy = (state != S_IDLE);

  always_comb begin
    asm_word   = {word_acc, i_rx_data};
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_nbytes = 5'd4;
    case (state)
      S_ACK_LD: begin
        ser_load = 1'b1;
`ifdef DEBUG_UNIT_CHECKSUM_EN
        ser_data[15:0] = {ACK_BYTE, k[7:0]};
        ser_nbytes     = 5'd2;
`else
        ser_data[7:0] = ACK_BYTE;
        ser_nbytes    = 5'd1;
`endif
      end
      S_REG_LAT: begin
        ser_load       = 1'b1;
        ser_data[31:0] = i_du_regs_mem_data;
      end
      S_MEM_LAT: begin
        ser_load       = 1'b1;
        ser_data[31:0] = i_du_mem_data;
      end
      S_LAT_LD: begin
        ser_load = 1'b1;
        case (lat_sel)
          2'd0: begin ser_data[63:0]  = snap_if_id; ser_nbytes = IF_ID_BYTES; end
          2'd1: begin ser_data[129:0] = snap_id_ex; ser_nbytes = ID_EX_BYTES; end
          2'd2: begin ser_data[75:0]  = snap_ex_m;  ser_nbytes = EX_M_BYTES;  end
          default: begin ser_data[70:0] = snap_m_wb; ser_nbytes = M_WB_BYTES; end
        endcase
      end
`ifdef DEBUG_UNIT_CHECKSUM_EN
      S_CSUM_LD: begin
        ser_load      = 1'b1;
        ser_data[7:0] = csum;
        ser_nbytes    = 5'd1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= S_IDLE;
      o_du_data         <= '0;
      o_du_inst_addr_wr <= '0;
      o_du_write_en     <= 1'b0;
      o_du_read_en      <= 1'b0;
      o_du_pipeline_en  <= 1'b0;
      k                 <= '0;
      bcnt              <= '0;
      word_acc          <= '0;
      idx               <= '0;
      lat_sel           <= '0;
      snap_if_id        <= '0;
      snap_id_ex        <= '0;
      snap_ex_m         <= '0;
      snap_m_wb         <= '0;
    end else begin
      o_du_write_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                k     <= '0;
                bcnt  <= '0;
                state <= S_LOAD;
              end
              CMD_RUN: begin
                if (i_du_halt) begin
                  state <= S_SNAP;
                end else begin
                  o_du_pipeline_en <= 1'b1;
                  state            <= S_RUN;
                end
              end
              CMD_STEP: begin
                o_du_pipeline_en <= 1'b1;
                state            <= S_STEP;
              end
              CMD_DUMP: state <= S_SNAP;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (i_rx_valid) begin
            word_acc <= asm_word[23:0];
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (k < MAX_INST) begin
                o_du_write_en     <= 1'b1;
                o_du_data         <= asm_word;
                o_du_inst_addr_wr <= {k[29:0], 2'b00};
              end
              k <= k + 32'd1;
              if (asm_word == HALT_INST) state <= S_ACK_LD;
            end
          end
        end
        S_ACK_LD: state <= S_ACK_TX;
        S_ACK_TX: if (ser_done) state <= S_IDLE;
        S_RUN: begin
          if (i_du_halt) begin
            o_du_pipeline_en <= 1'b0;
            state            <= S_SNAP;
          end
        end
        S_STEP: begin
          o_du_pipeline_en <= 1'b0;
          state            <= S_SNAP;
        end
        S_SNAP: begin
          snap_if_id        <= i_du_if_id_data;
          snap_id_ex        <= i_du_id_ex_data;
          snap_ex_m         <= i_du_ex_m_data;
          snap_m_wb         <= i_du_m_wb_data;
          idx               <= '0;
          o_du_read_en      <= 1'b1;
          o_du_inst_addr_wr <= '0;
          state             <= S_REG_REQ;
        end
        S_REG_REQ: begin
          o_du_read_en <= 1'b0;
          state        <= S_REG_LAT;
        end
        S_REG_LAT: state <= S_REG_TX;
        S_REG_TX: begin
          if (ser_done) begin
            if (idx == NB_REGS - 1) begin
              lat_sel <= '0;
              state   <= S_LAT_LD;
            end else begin
              idx               <= idx + 32'd1;
              o_du_read_en      <= 1'b1;
              o_du_inst_addr_wr <= idx + 32'd1;
              state             <= S_REG_REQ;
            end
          end
        end
        S_LAT_LD: state <= S_LAT_TX;
        S_LAT_TX: begin
          if (ser_done) begin
            if (lat_sel == 2'd3) begin
              idx               <= '0;
              o_du_read_en      <= 1'b1;
              o_du_inst_addr_wr <= '0;
              state             <= S_MEM_REQ;
            end else begin
              lat_sel <= lat_sel + 2'd1;
              state   <= S_LAT_LD;
            end
          end
        end
        S_MEM_REQ: begin
          o_du_read_en <= 1'b0;
          state        <= S_MEM_LAT;
        end
        S_MEM_LAT: state <= S_MEM_TX;
        S_MEM_TX: begin
          if (ser_done) begin
            if (idx == MEM_DUMP_WORDS - 1) begin
`ifdef DEBUG_UNIT_CHECKSUM_EN
              state <= S_CSUM_LD;
`else
              state <= S_IDLE;
`endif
            end else begin
              idx               <= idx + 32'd1;
              o_du_read_en      <= 1'b1;
              o_du_inst_addr_wr <= {idx[29:0] + 30'd1, 2'b00};
              state             <= S_MEM_REQ;
            end
          end
        end
        S_CSUM_LD: state <= S_CSUM_TX;
        S_CSUM_TX: if (ser_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DEBUG_UNIT_CHECKSUM_EN
  always_comb begin
    in_dump = 1'b0;
    case (state)
      S_REG_REQ, S_REG_LAT, S_REG_TX, S_LAT_LD, S_LAT_TX,
      S_MEM_REQ, S_MEM_LAT, S_MEM_TX: in_dump = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || state == S_SNAP) csum <= '0;
    else if (in_dump && o_tx_valid && i_tx_ready) csum <= csum ^ o_tx_data;
  end
`endif

  du_word_serializer u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_data     (ser_data),
    .i_nbytes   (ser_nbytes),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (ser_done)
  );

endmodule
